// File: rtl/mdll_pkg.sv
// ---------------------------------------------------------------------------
// mdll_pkg
// Shared types and constants for the MDLL digitally-controlled delay line
// coarse controller.
//   coarse_state_e : FSM state encoding (IDLE / STEP / SETTLE)
//   N_STG_DEF      : default number of coarse delay stages
//   SETTLE_W       : width of the settle counter (covers SETTLE_CYC 1..255)
// ---------------------------------------------------------------------------
package mdll_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STEP   = 2'd1,
    SETTLE = 2'd2
  } coarse_state_e;

  localparam int N_STG_DEF = 16;
  localparam int SETTLE_W  = 8;

endpackage : mdll_pkg

// File: rtl/mdll_dcdl_coarse_ctrl.sv
// ---------------------------------------------------------------------------
// mdll_dcdl_coarse_ctrl
// Walks the coarse delay code of the DCDL toward a requested target one stage
// at a time, waiting SETTLE_CYC cycles after every single-stage change so the
// delay line can settle before the next step.
//
// Parameters
//   N_STG      : number of coarse delay stages driven
//   SETTLE_CYC : cycles spent in SETTLE after each single-stage change (1..255)
//
// Ports
//   clk      in   block clock
//   rst      in   synchronous active-high reset
//   code_in  in   target coarse code (saturated to N_STG-1)
//   code_vld in   target valid; accepted only while code_rdy is high
//   code_rdy out  ready for a new target (IDLE only)
//   en_ff    out  per-stage feed-forward enable, thermometer coded
//   code_cur out  code currently applied to en_ff
//   done     out  one-cycle pulse when code_cur reaches the target
//   busy     out  high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module mdll_dcdl_coarse_ctrl
  import mdll_pkg::*;
#(
  parameter  int N_STG      = N_STG_DEF,
  parameter  int SETTLE_CYC = 4,
  localparam int CW         = $clog2(N_STG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CW-1:0]    code_in,
  input  logic             code_vld,
  output logic             code_rdy,
  output logic [N_STG-1:0] en_ff,
  output logic [CW-1:0]    code_cur,
  output logic             done,
  output logic             busy
);

  localparam logic [CW-1:0]       CODE_MAX  = CW'(N_STG - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE_CYC);

  coarse_state_e       state;
  logic [CW-1:0]       tgt;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [CW-1:0]       code_sat;

  // Clamp the request to the last stage; only matters when N_STG is not a
  // power of two and code_in can encode values past the end of the line.
  always_comb begin
    code_sat = code_in;
    if (32'(code_in) > N_STG - 1) begin
      code_sat = CODE_MAX;
    end
  end

  // Stepping FSM. en_ff is updated bit-by-bit alongside code_cur, so each
  // step sets or clears exactly one enable and en_ff stays a thermometer of
  // code_cur. The top enable can never be set because code_cur never
  // exceeds N_STG-1. The settle counter is loaded with SETTLE_CYC on each
  // step and leaves SETTLE when it reads 1, giving exactly SETTLE_CYC cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      code_cur   <= '0;
      tgt        <= '0;
      en_ff      <= '0;
      settle_cnt <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
      code_rdy   <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (code_vld && code_rdy) begin
            tgt      <= code_sat;
            state    <= STEP;
            busy     <= 1'b1;
            code_rdy <= 1'b0;
          end
        end
        STEP: begin
          if (code_cur == tgt) begin
            done     <= 1'b1;
            state    <= IDLE;
            busy     <= 1'b0;
            code_rdy <= 1'b1;
          end else begin
            if (code_cur < tgt) begin
              en_ff[code_cur] <= 1'b1;
              code_cur        <= code_cur + 1'b1;
            end else begin
              en_ff[code_cur - 1'b1] <= 1'b0;
              code_cur               <= code_cur - 1'b1;
            end
            settle_cnt <= SETTLE_LD;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt - 1'b1;
          if (settle_cnt == SETTLE_W'(1)) begin
            state <= STEP;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : mdll_dcdl_coarse_ctrl

// File: tb/tb_mdll_dcdl_coarse_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mdll_dcdl_coarse_ctrl
// Directed self-checking bench for the DCDL coarse controller with N_STG=16
// and SETTLE_CYC=4. Expected codes, enables and done/ready timing come from
// hand-derived values and a cycle formula for a single move.
// ---------------------------------------------------------------------------
module tb_mdll_dcdl_coarse_ctrl;

  localparam int N  = 16;
  localparam int S  = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] code_in;
  logic          code_vld;
  logic          code_rdy;
  logic [N-1:0]  en_ff;
  logic [CW-1:0] code_cur;
  logic          done;
  logic          busy;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;
  int done_cnt  = 0;

  logic         rst_seen = 1'b1;
  logic [N-1:0] en_prev  = '0;

  mdll_dcdl_coarse_ctrl #(
    .N_STG      (N),
    .SETTLE_CYC (S)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .code_in  (code_in),
    .code_vld (code_vld),
    .code_rdy (code_rdy),
    .en_ff    (en_ff),
    .code_cur (code_cur),
    .done     (done),
    .busy     (busy)
  );

  // Free-running block clock
  always #5 clk = ~clk;

  // Single comparison point; every check in the bench goes through here
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a target for one edge (acceptance edge = cycle 0)
  task automatic applyStimulus(input int code);
    code_in  = CW'(code);
    code_vld = 1'b1;
    tick();
    code_vld = 1'b0;
  endtask

  function automatic logic [N-1:0] thermo(input int n);
    return N'((32'd1 << n) - 32'd1);
  endfunction

  function automatic logic is_thermo(input logic [N-1:0] v);
    return (v == thermo($countones(v))) && !v[N-1];
  endfunction

  // Record whether reset was applied on the latest edge
  always @(posedge clk) rst_seen = rst;

  // Per-edge structural checks: at most one enable bit flips, enables remain a
  // thermometer code, and done never overlaps busy
  always @(negedge clk) begin
    if (!rst_seen) begin
      checkOutput("one_bit_flip", 32'($countones(en_ff ^ en_prev) <= 1), 32'd1);
      checkOutput("thermo_valid", 32'(is_thermo(en_ff)), 32'd1);
      checkOutput("done_not_busy", 32'(done && busy), 32'd0);
      if (done === 1'b1) done_cnt++;
    end
    en_prev = en_ff;
  end

  // One complete move from start to target, checked every cycle against the
  // timing formula; optionally pulses a stray code_vld=9 at glitch_c
  task automatic runMove(input int start, input int target, input int glitch_c, input string name);
    int k;
    int last;
    int steps;
    int code_exp;
    k    = (target > start) ? target - start : start - target;
    last = 1 + k * (1 + S);
    applyStimulus(target);
    checkOutput({name, "_c0_busy"}, 32'(busy), 32'd1);
    checkOutput({name, "_c0_rdy"}, 32'(code_rdy), 32'd0);
    checkOutput({name, "_c0_en"}, 32'(en_ff), 32'(thermo(start)));
    for (int c = 1; c <= last + 1; c++) begin
      if (c == glitch_c) begin
        code_in  = CW'(9);
        code_vld = 1'b1;
      end
      tick();
      code_vld = 1'b0;
      steps = (c - 1) / (1 + S) + 1;
      if (steps > k) steps = k;
      code_exp = (target >= start) ? start + steps : start - steps;
      checkOutput($sformatf("%s_c%0d_code", name, c), 32'(code_cur), 32'(code_exp));
      checkOutput($sformatf("%s_c%0d_en", name, c), 32'(en_ff), 32'(thermo(code_exp)));
      checkOutput($sformatf("%s_c%0d_done", name, c), 32'(done), 32'(c == last));
      checkOutput($sformatf("%s_c%0d_busy", name, c), 32'(busy), 32'(c < last));
      checkOutput($sformatf("%s_c%0d_rdy", name, c), 32'(code_rdy), 32'(c >= last));
    end
  endtask

  // Directed sequence
  initial begin
    int done_snap;
    rst      = 1'b1;
    code_in  = '0;
    code_vld = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Post-reset state
    checkOutput("rst_en", 32'(en_ff), 32'h0000);
    checkOutput("rst_code", 32'(code_cur), 32'd0);
    checkOutput("rst_rdy", 32'(code_rdy), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    tick();

    // 0 -> 3: enables 0x0001@1, 0x0003@6, 0x0007@11, done@16
    runMove(0, 3, -1, "up3");
    checkOutput("up3_final_code", 32'(code_cur), 32'd3);
    checkOutput("up3_final_en", 32'(en_ff), 32'h0007);

    // 3 -> 5, then 5 -> 2 down through 0x001F, 0x000F, 0x0007, 0x0003
    runMove(3, 5, -1, "up5");
    checkOutput("up5_final_en", 32'(en_ff), 32'h001F);
    runMove(5, 2, -1, "dn2");
    checkOutput("dn2_final_en", 32'(en_ff), 32'h0003);

    // Target equal to current code: done one cycle after acceptance
    runMove(2, 2, -1, "same");
    checkOutput("same_final_en", 32'(en_ff), 32'h0003);

    // Stray request while busy must be dropped
    runMove(2, 6, 3, "ign");
    tick();
    tick();
    checkOutput("ign_final_code", 32'(code_cur), 32'd6);
    checkOutput("ign_final_busy", 32'(busy), 32'd0);

    // Reset during SETTLE of a 0 -> 10 move
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    applyStimulus(10);
    tick();
    tick();
    tick();
    checkOutput("mid_settle_en", 32'(en_ff), 32'h0001);
    checkOutput("mid_settle_busy", 32'(busy), 32'd1);
    done_snap = done_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort_en", 32'(en_ff), 32'h0000);
    checkOutput("abort_code", 32'(code_cur), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_rdy", 32'(code_rdy), 32'd1);
    for (int i = 0; i < 20; i++) tick();
    checkOutput("abort_no_done", 32'(done_cnt), 32'(done_snap));
    checkOutput("abort_idle_code", 32'(code_cur), 32'd0);
    runMove(0, 1, -1, "post");
    checkOutput("post_final_en", 32'(en_ff), 32'h0001);

    tick();
    $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_mdll_dcdl_coarse_ctrl

// File: doc/mdll_dcdl_coarse_ctrl.md
MDLL_DCDL_COARSE_CTRL -- requirements
Module: mdll_dcdl_coarse_ctrl

Interface
REQ-001 SHALL have parameter N_STG, default 16, meaning the number of coarse delay stages driven.
REQ-002 SHALL have parameter SETTLE_CYC, default 4, legal range 1..255, meaning the clk cycles the block waits after each single-stage change.
REQ-003 SHALL have port clk  input  1  block clock; single clock domain.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port code_in  input  CW=$clog2(N_STG)  target coarse code.
REQ-006 SHALL have port code_vld  input  1  target code valid.
REQ-007 SHALL have port code_rdy  output  1  block ready to accept a new target.
REQ-008 SHALL have port en_ff  output  N_STG  per-stage feed-forward enable, in thermometer code.
REQ-009 SHALL have port code_cur  output  CW  code currently applied to en_ff.
REQ-010 SHALL have port done  output  1  one-cycle pulse when code_cur reaches the target.
REQ-011 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 SHALL drive en_ff[i]=1 for i<code_cur and en_ff[i]=0 for i>=code_cur. The stage at index code_cur is the fold-back stage, and en_ff[N_STG-1] is always 0.
REQ-013 SHALL use FSM states IDLE, STEP and SETTLE.
REQ-014 SHALL assert code_rdy only in IDLE, and SHALL accept a target on a clk edge where code_vld && code_rdy. A code_vld seen outside IDLE is ignored and not queued.
REQ-015 SHALL saturate the accepted code_in to N_STG-1 when it exceeds N_STG-1. Only reachable for non-power-of-2 N_STG.
REQ-016 SHALL make the transition IDLE->STEP on acceptance and latch the target into an internal tgt register.
REQ-017 SHALL, in STEP:
- if code_cur != tgt: change code_cur by exactly +/-1 toward tgt, which flips exactly one en_ff bit; load the settle counter with SETTLE_CYC; go to SETTLE.
- if code_cur == tgt: pulse done and go to IDLE.
REQ-018 SHALL, in SETTLE, decrement the counter each cycle and go to STEP when the counter expires, so the state spends exactly SETTLE_CYC cycles in SETTLE.
REQ-019 SHALL implement the net cycle timing below, with acceptance at cycle 0 and k = |tgt - code_cur|:
- en_ff changes at cycles 1, 1+(1+SETTLE_CYC), ...
- done and code_rdy both assert at cycle 1 + k*(1+SETTLE_CYC).
REQ-020 SHALL never change more than one en_ff bit per clk edge, except under reset.
REQ-021 SHALL register all outputs with no combinational path from inputs to outputs.
REQ-022 SHALL treat k=0 as legal: done pulses at cycle 1 and en_ff is unchanged.
REQ-023 SHALL hold busy = (state != IDLE), and SHALL ensure done never coincides with busy=1.

Reset
REQ-024 SHALL, on any clk edge with rst=1 (including mid-STEP or mid-SETTLE), force:
- state to IDLE;
- code_cur, tgt, en_ff and the settle counter to 0;
- done and busy to 0;
- code_rdy to 1 from the first cycle after rst deasserts.
REQ-025 SHALL accept a multi-bit en_ff change to all-zero (minimum delay) caused by reset. Downstream treats the clock as invalid during reset.

Structure
REQ-026 SHALL place the FSM state enum type and the default N_STG constant in mdll_pkg. CW is derived locally.
REQ-027 SHALL be a single flat module with no sub-modules. The thermometer decode and settle counter are inline.

Verification
REQ-028 SHALL cover the following directed scenarios with N_STG=16 and SETTLE_CYC=4:
- Post-reset: en_ff=16'h0000, code_cur=0, code_rdy=1, busy=0, done=0.
- code_in=3 accepted at cycle 0: en_ff becomes 0x0001@1, 0x0003@6, 0x0007@11; done and code_rdy assert @16; code_cur=3.
- From code_cur=5, code_in=2: en_ff steps 0x001F->0x000F->0x0007->0x0003, one bit per step; done @16.
- code_in equal to code_cur: done @1, en_ff unchanged, busy high for exactly one cycle.
- code_vld pulsed with code_in=9 while busy: ignored; final code_cur equals the original target.
- rst asserted during SETTLE of the 0->10 move: en_ff=0 and state IDLE on the next edge; no done pulse; a new code_in=1 is then accepted normally.
REQ-029 SHALL include a bench assertion that popcount(en_ff ^ en_ff_prev) <= 1 on every non-reset edge, and that en_ff is always a valid thermometer code.
